// File: rtl/apb_sram_requester.sv
// apb_sram_requester: APB requester that turns one accepted command into one
// SETUP+ACCESS transfer, absorbs PREADY wait states and returns read data
// plus PSLVERR status as a one-cycle response pulse.
// Optional feature macro: APB_REQ_TIMEOUT_EN (bounds the ACCESS wait to
// TIMEOUT_CYCLES cycles and reports an error on expiry).
module apb_sram_requester #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  prst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic                  cmd_ready_reg, cmd_ready_next;
    logic                  psel_reg, psel_next;
    logic                  penable_reg, penable_next;
    logic                  pwrite_reg, pwrite_next;
    logic [ADDR_WIDTH-1:0] paddr_reg, paddr_next;
    logic [DATA_WIDTH-1:0] pwdata_reg, pwdata_next;
    logic                  rsp_valid_reg, rsp_valid_next;
    logic [DATA_WIDTH-1:0] rsp_rdata_reg, rsp_rdata_next;
    logic                  rsp_err_reg, rsp_err_next;
    logic                  timeout_hit;

`ifdef APB_REQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_reg;

    // Count consecutive ACCESS cycles with pready low; cleared outside ACCESS,
    // so it starts from zero on every SETUP->ACCESS step.
    always_ff @(posedge pclk) begin
        if (prst || state_reg != ACCESS) begin
            wait_cnt_reg <= '0;
        end else if (!pready) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end
    end

    // The last allowed wait cycle: abort at the edge closing it unless pready wins.
    assign timeout_hit = (state_reg == ACCESS) && !pready &&
                         (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State and registered-output update; reset abandons any transfer in flight.
    always_ff @(posedge pclk) begin
        if (prst) begin
            state_reg     <= IDLE;
            cmd_ready_reg <= 1'b0;
            psel_reg      <= 1'b0;
            penable_reg   <= 1'b0;
            pwrite_reg    <= 1'b0;
            paddr_reg     <= '0;
            pwdata_reg    <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cmd_ready_reg <= cmd_ready_next;
            psel_reg      <= psel_next;
            penable_reg   <= penable_next;
            pwrite_reg    <= pwrite_next;
            paddr_reg     <= paddr_next;
            pwdata_reg    <= pwdata_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_err_reg   <= rsp_err_next;
        end
    end

    // Next-state and next-output decode; everything holds unless a transition changes it.
    always_comb begin
        state_next     = state_reg;
        cmd_ready_next = cmd_ready_reg;
        psel_next      = psel_reg;
        penable_next   = penable_reg;
        pwrite_next    = pwrite_reg;
        paddr_next     = paddr_reg;
        pwdata_next    = pwdata_reg;
        rsp_valid_next = 1'b0;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_err_next   = rsp_err_reg;

        case (state_reg)
            IDLE: begin
                cmd_ready_next = 1'b1;
                if (cmd_valid && cmd_ready_reg) begin
                    state_next     = SETUP;
                    cmd_ready_next = 1'b0;
                    psel_next      = 1'b1;
                    penable_next   = 1'b0;
                    pwrite_next    = cmd_write;
                    paddr_next     = cmd_addr;
                    pwdata_next    = cmd_wdata;
                end
            end
            SETUP: begin
                state_next   = ACCESS;
                psel_next    = 1'b1;
                penable_next = 1'b1;
            end
            ACCESS: begin
                if (pready) begin
                    state_next     = IDLE;
                    cmd_ready_next = 1'b1;
                    psel_next      = 1'b0;
                    penable_next   = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_rdata_next = pwrite_reg ? '0 : prdata;
                    rsp_err_next   = pslverr;
                end else if (timeout_hit) begin
                    state_next     = IDLE;
                    cmd_ready_next = 1'b1;
                    psel_next      = 1'b0;
                    penable_next   = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_rdata_next = '0;
                    rsp_err_next   = 1'b1;
                end
            end
            default: begin
                state_next     = IDLE;
                cmd_ready_next = 1'b0;
                psel_next      = 1'b0;
                penable_next   = 1'b0;
            end
        endcase
    end

    assign cmd_ready = cmd_ready_reg;
    assign psel      = psel_reg;
    assign penable   = penable_reg;
    assign pwrite    = pwrite_reg;
    assign paddr     = paddr_reg;
    assign pwdata    = pwdata_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_apb_sram_requester.sv
// tb_apb_sram_requester: directed plus randomized transfers against
// apb_sram_requester, with the bench acting as the APB SRAM completer and a
// command-level memory model supplying expected read data.
module tb_apb_sram_requester;

    logic        pclk;
    logic        prst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int errors = 0;
    int checks = 0;

    logic [31:0] model_mem [logic [31:0]];
    logic [31:0] completer_mem [logic [31:0]];

    apb_sram_requester #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .pclk     (pclk),
        .prst     (prst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] completer_rd(input logic [31:0] a);
        return completer_mem.exists(a) ? completer_mem[a] : 32'h0;
    endfunction

    // Garbage on the command port while a transfer is in flight must be ignored.
    task automatic scramble_cmd();
        cmd_valid = 1'($urandom);
        cmd_write = 1'($urandom);
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
    endtask

    // One complete transfer, entered and left at a negedge with the DUT idle.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input int waits, input bit err);
        logic [31:0] exp_rdata;
        exp_rdata = wr ? 32'h0 : model_rd(addr);
        if (wr) model_mem[addr] = data;
        check("idle_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data;
        pready = 1'b0; pslverr = 1'b0;
        @(negedge pclk);
        check("setup_psel_penable", {psel, penable}, 2'b10);
        check("setup_bus", {pwrite, paddr, pwdata}, {wr, addr, data});
        check("setup_cmd_ready", cmd_ready, 0);
        scramble_cmd();
        @(negedge pclk);
        for (int w = 0; w <= waits; w++) begin
            check("access_psel_penable", {psel, penable}, 2'b11);
            check("access_bus", {pwrite, paddr, pwdata}, {wr, addr, data});
            check("access_no_rsp", {rsp_valid, cmd_ready}, 2'b00);
            if (w == waits) begin
                pready  = 1'b1;
                pslverr = err;
                prdata  = pwrite ? $urandom : completer_rd(paddr);
                if (pwrite) completer_mem[paddr] = pwdata;
            end else begin
                pready  = 1'b0;
                pslverr = 1'($urandom);
                prdata  = $urandom;
            end
            scramble_cmd();
            @(negedge pclk);
        end
        pready = 1'b0; pslverr = 1'b0; cmd_valid = 1'b0;
        check("rsp_valid", rsp_valid, 1);
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_err", rsp_err, err);
        check("done_psel_penable", {psel, penable}, 2'b00);
        check("done_bus_hold", {pwrite, paddr}, {wr, addr});
        @(negedge pclk);
        check("rsp_pulse_end", rsp_valid, 0);
        check("rsp_hold", {rsp_err, rsp_rdata}, {err, exp_rdata});
        $display("xfer %s addr=%08h data=%08h waits=%0d err=%0d rdata=%08h",
                 wr ? "WR" : "RD", addr, data, waits, err, rsp_rdata);
    endtask

    initial begin
        int setup_k[$];
        int rsp_cnt;
        int acc_cycles;
        bit seen;
        logic [31:0] r_addr;

        prst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        prdata = '0; pready = 1'b0; pslverr = 1'b0;
        repeat (3) @(negedge pclk);
        check("reset_cmd_ready", cmd_ready, 0);
        check("reset_apb", {psel, penable, pwrite, paddr, pwdata}, 67'h0);
        check("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, 34'h0);
        prst = 1'b0;
        @(negedge pclk);
        check("post_reset_ready", cmd_ready, 1);

        // Zero-wait write, then a read with three wait states.
        xfer(1'b1, 32'h10, 32'hA5A5_0001, 0, 1'b0);
        xfer(1'b0, 32'h10, 32'h0, 3, 1'b0);
        check("read_back_value", rsp_rdata, 32'hA5A5_0001);

        // Slave error on one read, clean status on the following one.
        xfer(1'b0, 32'h10, 32'h0, 1, 1'b1);
        xfer(1'b0, 32'h10, 32'h0, 0, 1'b0);

        // cmd_valid held high across four writes: one SETUP every third cycle.
        rsp_cnt = 0;
        pready = 1'b1; pslverr = 1'b0; prdata = '0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h100; cmd_wdata = $urandom;
        for (int k = 1; k <= 15; k++) begin
            @(negedge pclk);
            if (psel && !penable) begin
                setup_k.push_back(k);
                check("b2b_setup_addr", paddr, 32'h100 + 32'(4 * (setup_k.size() - 1)));
                if (setup_k.size() == 4) begin
                    cmd_valid = 1'b0;
                end else begin
                    cmd_addr  = 32'h100 + 32'(4 * setup_k.size());
                    cmd_wdata = $urandom;
                end
            end
            if (psel) check("b2b_ready_low", cmd_ready, 0);
            if (rsp_valid) rsp_cnt++;
        end
        pready = 1'b0;
        check("b2b_transfers", setup_k.size(), 4);
        check("b2b_responses", rsp_cnt, 4);
        for (int i = 1; i < setup_k.size(); i++)
            check("b2b_spacing", setup_k[i] - setup_k[i-1], 3);
        $display("b2b setups=%0d responses=%0d", setup_k.size(), rsp_cnt);

        // Reset during ACCESS abandons the transfer.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20; pready = 1'b0;
        @(negedge pclk);
        cmd_valid = 1'b0;
        @(negedge pclk);
        check("pre_reset_access", {psel, penable}, 2'b11);
        prst = 1'b1;
        @(negedge pclk);
        check("midreset_apb", {psel, penable, paddr}, 34'h0);
        check("midreset_rsp", {rsp_valid, cmd_ready}, 2'b00);
        prst = 1'b0;
        @(negedge pclk);
        check("after_reset_ready", cmd_ready, 1);
        check("after_reset_no_rsp", {rsp_valid, psel}, 2'b00);
        $display("reset mid-transfer psel=%0d rsp_valid=%0d cmd_ready=%0d", psel, rsp_valid, cmd_ready);

`ifdef APB_REQ_TIMEOUT_EN
        // pready stuck low: the requester gives up after 16 wait cycles.
        acc_cycles = 0; seen = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h44; pready = 1'b0;
        @(negedge pclk);
        cmd_valid = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge pclk);
            if (rsp_valid) seen = 1'b1;
            else if (psel && penable) acc_cycles++;
        end
        check("timeout_seen", seen, 1);
        check("timeout_access_cycles", acc_cycles, 16);
        check("timeout_err", {rsp_err, rsp_rdata}, {1'b1, 32'h0});
        check("timeout_idle", {psel, penable, cmd_ready}, 3'b001);
        $display("timeout access_cycles=%0d rsp_err=%0d", acc_cycles, rsp_err);
        @(negedge pclk);
`endif

        // Randomized traffic over a small address set against the memory model.
        for (int n = 0; n < 24; n++) begin
            r_addr = 32'h200 + 32'(4 * $urandom_range(0, 3));
            xfer(1'($urandom), r_addr, $urandom, int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
